wash_sequencer: RTL and testbench
=================================

WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 4, clock cycles per timing tick (at least 2).
REQ-002 Parameter FILL_TICKS, default 3, FILL phase duration in ticks.
REQ-003 Parameter SPIN_TICKS, default 5, SPIN and ABORT phase duration in ticks.
REQ-004 Parameter DRY_TICKS, default 6, DRY phase duration in ticks.
REQ-005 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 control_start  input  1  level request to run a cycle, from the control register file.
REQ-009 control_drying  input  1  enables the DRY phase.
REQ-010 control_preset  input  2  rinse length selector.
REQ-011 washing_time  input  8  WASH duration in ticks.
REQ-012 valve_fill  output  1  water inlet valve.
REQ-013 motor_wash  output  1  drum slow rotation.
REQ-014 motor_spin  output  1  drum fast rotation.
REQ-015 drain  output  1  drain pump.
REQ-016 heater_dry  output  1  dryer heater.
REQ-017 busy  output  1  high in every state except IDLE and DONE.
REQ-018 done  output  1  high in DONE only.
REQ-019 state  output  3  current state code.
REQ-020 remaining  output  8  ticks left in the current phase.

Function
REQ-021 States and codes: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, DRY=5, DONE=6, ABORT=7.
REQ-022 In IDLE with control_start=1 at a clock edge, the block SHALL enter FILL on that edge.
  - Same edge latches control_drying, control_preset and washing_time.
  - Same edge clears the prescaler to 0.
REQ-023 The prescaler SHALL count 0..TICK_DIV-1 and wrap. A tick is the cycle in which the prescaler equals TICK_DIV-1. The prescaler holds 0 in IDLE and DONE.
REQ-024 On entry to each timed phase, remaining SHALL load that phase's duration.
  - On each tick, remaining decrements by 1.
  - A tick with remaining=1 ends the phase on that edge.
  - Every timed phase therefore lasts exactly duration*TICK_DIV cycles.
REQ-025 Phase durations:
  - FILL = FILL_TICKS.
  - WASH = latched washing_time; a value of 0 is treated as 1.
  - RINSE = 4*(latched preset+1), i.e. 4, 8, 12 or 16 ticks (width 5 internally, fits 8).
  - SPIN = SPIN_TICKS; DRY = DRY_TICKS; ABORT = SPIN_TICKS.
REQ-026 Normal transition order: FILL -> WASH -> RINSE -> SPIN. SPIN goes to DRY if latched drying=1, else to DONE. DRY -> DONE.
REQ-027 Outputs are Moore and decoded from state:
  - FILL: valve_fill.
  - WASH: motor_wash.
  - RINSE: valve_fill and motor_wash.
  - SPIN: motor_spin and drain.
  - DRY: heater_dry and motor_wash.
  - ABORT: drain only.
  - All other outputs are 0.
REQ-028 If control_start=0 at an edge while in FILL, WASH or RINSE, the block SHALL enter ABORT on that edge. Abort has priority over a phase end occurring on the same edge.
REQ-029 control_start=0 during SPIN or DRY SHALL be ignored; that phase completes normally.
REQ-030 ABORT SHALL end in IDLE. A subsequent start requires control_start=1 while in IDLE.
REQ-031 DONE SHALL hold until control_start=0, then return to IDLE. This prevents auto-restart while the register bit stays set.
REQ-032 Input changes after the start edge SHALL NOT affect durations or the DRY decision; only control_start is monitored.
REQ-033 remaining SHALL read 0 in IDLE and DONE.

Reset
REQ-034 rst_n=0 SHALL immediately force state=IDLE, prescaler=0, remaining=0, latched configuration=0, and all control outputs, busy and done to 0, independent of clk.
REQ-035 Reset asserted mid-cycle SHALL abandon the cycle. After release the block sits in IDLE and starts again only on control_start=1.

Verification
REQ-036 Defaults; washing_time=5, preset=01, drying=0, start held high -> FILL 12 cycles, WASH 20, RINSE 32, SPIN 20; done=1 84 cycles after entering FILL; start then low -> IDLE next edge.
REQ-037 As REQ-036 with drying=1 -> DRY with heater_dry=1 for 24 cycles after SPIN; done asserted 108 cycles after entering FILL.
REQ-038 washing_time=0, preset=00 -> WASH lasts 4 cycles, RINSE lasts 16 cycles.
REQ-039 start dropped during RINSE -> ABORT next edge with drain=1 only for 20 cycles, then IDLE, done never asserted; start dropped during SPIN -> cycle completes to DONE.
REQ-040 Change washing_time from 5 to 200 during FILL -> WASH still lasts 20 cycles; rst_n pulsed low during WASH -> outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/wash_sequencer.sv
// wash_sequencer: timed wash-cycle controller.
//   Sequence: FILL -> WASH -> RINSE -> SPIN -> (DRY) -> DONE.
//   Dropping control_start during FILL, WASH or RINSE diverts to ABORT, which drains and returns to IDLE.
//   Phase lengths are counted in ticks. One tick is TICK_DIV clock cycles.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   control_start   level run request (monitored throughout a cycle)
//   control_drying  enable DRY phase (latched at start)
//   control_preset  rinse length selector (latched at start)
//   washing_time    WASH length in ticks (latched at start)
//   valve_fill, motor_wash, motor_spin, drain, heater_dry   actuator outputs (Moore)
//   busy, done      status
//   state           current state code
//   remaining       ticks left in current phase
module wash_sequencer #(
    parameter int unsigned TICK_DIV   = 4,
    parameter int unsigned FILL_TICKS = 3,
    parameter int unsigned SPIN_TICKS = 5,
    parameter int unsigned DRY_TICKS  = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       control_start,
    input  logic       control_drying,
    input  logic [1:0] control_preset,
    input  logic [7:0] washing_time,
    output logic       valve_fill,
    output logic       motor_wash,
    output logic       motor_spin,
    output logic       drain,
    output logic       heater_dry,
    output logic       busy,
    output logic       done,
    output logic [2:0] state,
    output logic [7:0] remaining
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_RINSE = 3'd3,
        S_SPIN  = 3'd4,
        S_DRY   = 3'd5,
        S_DONE  = 3'd6,
        S_ABORT = 3'd7
    } state_t;

    localparam int unsigned PW = $clog2(TICK_DIV);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    rem_q, rem_d;
    logic          drying_q, drying_d;
    logic [1:0]    preset_q, preset_d;
    logic [7:0]    wtime_q, wtime_d;

    logic          tick;
    logic [4:0]    rinse_ticks;
    logic [7:0]    wash_ticks;
    state_t        nxt;
    logic [7:0]    nxt_dur;

    assign tick        = (presc_q == PW'(TICK_DIV - 1));
    assign rinse_ticks = ({3'b000, preset_q} + 5'd1) << 2;
    assign wash_ticks  = (wtime_q == 8'd0) ? 8'd1 : wtime_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            rem_q    <= '0;
            drying_q <= 1'b0;
            preset_q <= '0;
            wtime_q  <= '0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            rem_q    <= rem_d;
            drying_q <= drying_d;
            preset_q <= preset_d;
            wtime_q  <= wtime_d;
        end
    end

    // Successor of each timed phase and the duration it loads on entry.
    always_comb begin
        nxt     = S_IDLE;
        nxt_dur = '0;
        case (state_q)
            S_FILL:  begin nxt = S_WASH;  nxt_dur = wash_ticks; end
            S_WASH:  begin nxt = S_RINSE; nxt_dur = {3'b000, rinse_ticks}; end
            S_RINSE: begin nxt = S_SPIN;  nxt_dur = 8'(SPIN_TICKS); end
            S_SPIN:  begin
                if (drying_q) begin
                    nxt     = S_DRY;
                    nxt_dur = 8'(DRY_TICKS);
                end else begin
                    nxt = S_DONE;
                end
            end
            S_DRY:   nxt = S_DONE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        presc_d  = '0;
        rem_d    = rem_q;
        drying_d = drying_q;
        preset_d = preset_q;
        wtime_d  = wtime_q;
        case (state_q)
            S_IDLE: begin
                rem_d = '0;
                if (control_start) begin
                    state_d  = S_FILL;
                    rem_d    = 8'(FILL_TICKS);
                    drying_d = control_drying;
                    preset_d = control_preset;
                    wtime_d  = washing_time;
                end
            end
            S_DONE: begin
                rem_d = '0;
                if (!control_start) state_d = S_IDLE;
            end
            default: begin
                // Phase boundaries always coincide with the prescaler wrap, so the
                // prescaler only needs an explicit clear when ABORT cuts a phase short.
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (!control_start && (state_q == S_FILL || state_q == S_WASH ||
                                       state_q == S_RINSE)) begin
                    state_d = S_ABORT;
                    rem_d   = 8'(SPIN_TICKS);
                    presc_d = '0;
                end else if (tick) begin
                    if (rem_q == 8'd1) begin
                        state_d = nxt;
                        rem_d   = nxt_dur;
                    end else begin
                        rem_d = rem_q - 8'd1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        valve_fill = 1'b0;
        motor_wash = 1'b0;
        motor_spin = 1'b0;
        drain      = 1'b0;
        heater_dry = 1'b0;
        case (state_q)
            S_FILL:  valve_fill = 1'b1;
            S_WASH:  motor_wash = 1'b1;
            S_RINSE: begin valve_fill = 1'b1; motor_wash = 1'b1; end
            S_SPIN:  begin motor_spin = 1'b1; drain = 1'b1; end
            S_DRY:   begin heater_dry = 1'b1; motor_wash = 1'b1; end
            S_ABORT: drain = 1'b1;
            default: ;
        endcase
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign state     = state_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_wash_sequencer.sv
module tb_wash_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       control_start;
    logic       control_drying;
    logic [1:0] control_preset;
    logic [7:0] washing_time;
    logic       valve_fill, motor_wash, motor_spin, drain, heater_dry, busy, done;
    logic [2:0] state;
    logic [7:0] remaining;

    int n_tests = 0;
    int n_fail  = 0;

    wash_sequencer #(
        .TICK_DIV(4), .FILL_TICKS(3), .SPIN_TICKS(5), .DRY_TICKS(6)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .control_start(control_start), .control_drying(control_drying),
        .control_preset(control_preset), .washing_time(washing_time),
        .valve_fill(valve_fill), .motor_wash(motor_wash), .motor_spin(motor_spin),
        .drain(drain), .heater_dry(heater_dry), .busy(busy), .done(done),
        .state(state), .remaining(remaining)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] wt;
        logic [1:0] preset;
        logic       drying;
        int         wash_t, rinse_t;
        int         wash_c, rinse_c, dry_c;
        int         done_c;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // {valve_fill, motor_wash, motor_spin, drain, heater_dry, busy, done}
    function automatic logic [6:0] exp_outs(input logic [2:0] st);
        case (st)
            3'd1:    return 7'b1000010;
            3'd2:    return 7'b0100010;
            3'd3:    return 7'b1100010;
            3'd4:    return 7'b0011010;
            3'd5:    return 7'b0100110;
            3'd6:    return 7'b0000001;
            3'd7:    return 7'b0001010;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic chk_outs(input string nm, input logic [2:0] st);
        chk(nm, int'({valve_fill, motor_wash, motor_spin, drain, heater_dry, busy, done}),
            int'(exp_outs(st)));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks outputs and the remaining count every cycle while in phase st, starting
    // at cycle index n0. Stops early at cycle index stop_at (if nonzero) without
    // checking length; otherwise the phase length must equal exp_len.
    task automatic run_phase(input string nm, input logic [2:0] st, input int ticks,
                             input int exp_len, input int n0, input int stop_at,
                             output int n);
        n = n0;
        while (state == st && n < 3000) begin
            if (stop_at > 0 && n == stop_at) break;
            chk({nm, " remaining"}, int'(remaining), ticks - n / 4);
            chk_outs({nm, " outputs"}, st);
            step();
            n++;
        end
        if (stop_at == 0) chk({nm, " length"}, n, exp_len);
        else chk({nm, " still in phase"}, int'(state), int'(st));
    endtask

    task automatic do_reset();
        control_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        chk("reset state", int'(state), 0);
        chk("reset remaining", int'(remaining), 0);
        chk_outs("reset outputs", 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic start_cycle(input logic [7:0] wt, input logic [1:0] pr, input logic dr);
        washing_time   = wt;
        control_preset = pr;
        control_drying = dr;
        control_start  = 1'b1;
        step();
        chk("enter FILL", int'(state), 1);
    endtask

    initial begin
        int n, total;
        vecs[0] = '{wt: 8'd5,   preset: 2'd1, drying: 1'b0, wash_t: 5,   rinse_t: 8,
                    wash_c: 20,   rinse_c: 32, dry_c: 0,  done_c: 84};
        vecs[1] = '{wt: 8'd5,   preset: 2'd1, drying: 1'b1, wash_t: 5,   rinse_t: 8,
                    wash_c: 20,   rinse_c: 32, dry_c: 24, done_c: 108};
        vecs[2] = '{wt: 8'd0,   preset: 2'd0, drying: 1'b0, wash_t: 1,   rinse_t: 4,
                    wash_c: 4,    rinse_c: 16, dry_c: 0,  done_c: 52};
        vecs[3] = '{wt: 8'd2,   preset: 2'd3, drying: 1'b1, wash_t: 2,   rinse_t: 16,
                    wash_c: 8,    rinse_c: 64, dry_c: 24, done_c: 128};
        vecs[4] = '{wt: 8'd255, preset: 2'd2, drying: 1'b0, wash_t: 255, rinse_t: 12,
                    wash_c: 1020, rinse_c: 48, dry_c: 0,  done_c: 1100};

        rst_n = 1'b1;
        control_start  = 1'b0;
        control_drying = 1'b0;
        control_preset = 2'd0;
        washing_time   = 8'd0;
        #2;
        do_reset();
        chk("idle after reset", int'(state), 0);

        // Table-driven full cycles
        foreach (vecs[i]) begin
            start_cycle(vecs[i].wt, vecs[i].preset, vecs[i].drying);
            total = 0;
            run_phase("FILL", 3'd1, 3, 12, 0, 0, n);               total += n;
            run_phase("WASH", 3'd2, vecs[i].wash_t, vecs[i].wash_c, 0, 0, n);   total += n;
            run_phase("RINSE", 3'd3, vecs[i].rinse_t, vecs[i].rinse_c, 0, 0, n); total += n;
            run_phase("SPIN", 3'd4, 5, 20, 0, 0, n);               total += n;
            if (vecs[i].drying) begin
                run_phase("DRY", 3'd5, 6, vecs[i].dry_c, 0, 0, n); total += n;
            end
            chk("cycles to DONE", total, vecs[i].done_c);
            chk("DONE state", int'(state), 6);
            chk_outs("DONE outputs", 3'd6);
            chk("DONE remaining", int'(remaining), 0);
            for (int k = 0; k < 3; k++) begin
                step();
                chk("DONE held while start high", int'(state), 6);
            end
            control_start = 1'b0;
            step();
            chk("DONE to IDLE", int'(state), 0);
            chk_outs("IDLE outputs", 3'd0);
            chk("IDLE remaining", int'(remaining), 0);
        end

        // Abort wins over the FILL phase end on the same edge
        start_cycle(8'd5, 2'd1, 1'b0);
        run_phase("FILL", 3'd1, 3, 12, 0, 11, n);
        control_start = 1'b0;
        step();
        chk("abort priority state", int'(state), 7);
        run_phase("ABORT", 3'd7, 5, 20, 0, 0, n);
        chk("ABORT to IDLE", int'(state), 0);

        // Abort in the middle of RINSE
        start_cycle(8'd5, 2'd1, 1'b1);
        run_phase("FILL", 3'd1, 3, 12, 0, 0, n);
        run_phase("WASH", 3'd2, 5, 20, 0, 0, n);
        run_phase("RINSE", 3'd3, 8, 32, 0, 5, n);
        control_start = 1'b0;
        step();
        chk("RINSE abort state", int'(state), 7);
        run_phase("ABORT", 3'd7, 5, 20, 0, 0, n);
        chk("ABORT to IDLE", int'(state), 0);
        chk("no done after abort", int'(done), 0);
        step();
        chk("IDLE stays without start", int'(state), 0);

        // Dropping start during SPIN is ignored
        start_cycle(8'd5, 2'd1, 1'b0);
        run_phase("FILL", 3'd1, 3, 12, 0, 0, n);
        run_phase("WASH", 3'd2, 5, 20, 0, 0, n);
        run_phase("RINSE", 3'd3, 8, 32, 0, 0, n);
        run_phase("SPIN", 3'd4, 5, 20, 0, 7, n);
        control_start = 1'b0;
        run_phase("SPIN", 3'd4, 5, 20, 7, 0, n);
        chk("SPIN drop reaches DONE", int'(state), 6);
        chk("SPIN drop done", int'(done), 1);
        step();
        chk("DONE to IDLE (start low)", int'(state), 0);

        // Inputs changed after start have no effect
        start_cycle(8'd5, 2'd1, 1'b0);
        run_phase("FILL", 3'd1, 3, 12, 0, 3, n);
        washing_time   = 8'd200;
        control_preset = 2'd3;
        control_drying = 1'b1;
        run_phase("FILL", 3'd1, 3, 12, 3, 0, n);
        run_phase("WASH latched", 3'd2, 5, 20, 0, 0, n);
        run_phase("RINSE latched", 3'd3, 8, 32, 0, 0, n);
        run_phase("SPIN", 3'd4, 5, 20, 0, 0, n);
        chk("drying latched off", int'(state), 6);
        control_start = 1'b0;
        step();
        chk("DONE to IDLE", int'(state), 0);

        // Asynchronous reset in the middle of WASH
        start_cycle(8'd5, 2'd1, 1'b0);
        run_phase("FILL", 3'd1, 3, 12, 0, 0, n);
        run_phase("WASH", 3'd2, 5, 20, 0, 6, n);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset state", int'(state), 0);
        chk("async reset remaining", int'(remaining), 0);
        chk_outs("async reset outputs", 3'd0);
        control_start = 1'b0;
        step();
        step();
        chk("held in reset", int'(state), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("IDLE after release", int'(state), 0);
        step();
        chk("IDLE without start", int'(state), 0);
        start_cycle(8'd5, 2'd1, 1'b0);
        run_phase("FILL after reset", 3'd1, 3, 12, 0, 0, n);
        chk("WASH after reset", int'(state), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
